// File: rtl/addr4u_serial_checker.sv
// Bit-serial checker for the unsigned adder: recovers A = S - B LSB-first, compares it
// against the supplied A, and keeps a saturating count of faulty results handed off.
module addr4u_serial_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_diff,
  output logic             out_ok,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int IDX_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   s_q, diff, bz;
  logic [IDX_W-1:0] idx;
  logic             borrow, sb, sbit, d, borrow_nx, last;

  // b zero-extended so the top step subtracts 0 with no out-of-range select
  assign bz        = {1'b0, b_q};
  assign sb        = bz[idx];
  assign sbit      = s_q[idx];
  assign d         = sbit ^ sb ^ borrow;
  assign borrow_nx = (~sbit & sb) | (~(sbit ^ sb) & borrow);
  assign last      = (idx == IDX_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SUB;
      end
      SUB:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are pure functions of held registers, so they are stable under backpressure
  assign out_diff = out_valid ? diff : '0;
  assign out_ok   = out_valid && (diff == {1'b0, a_q}) && !borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_q    <= b;
          s_q    <= s;
          borrow <= 1'b0;
          idx    <= '0;
        end
        SUB: begin
          borrow    <= borrow_nx;
          diff[idx] <= d;
          idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (out_valid && out_ready && !out_ok && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end
endmodule

// File: tb/tb_addr4u_serial_checker.sv
// Scoreboard bench for addr4u_serial_checker: expected {diff, ok} queued at accept,
// popped at the output handshake; error counter tracked by a small model.
module tb_addr4u_serial_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] a = '0, b = '0;
  logic [4:0] s = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [4:0] out_diff;
  logic       out_ok;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;

  typedef struct { logic [4:0] d; logic ok; } exp_t;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0, mcnt = 0;

  addr4u_serial_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_ok(out_ok), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int ta, input int tb_, input int ts);
    exp_t e;
    int   dd;
    dd   = ts - tb_;
    e.d  = 5'(dd & 31);
    e.ok = (dd >= 0) && (dd == ta);
    return e;
  endfunction

  // Called and returns at a negedge; hold = cycles of out_ready=0 once out_valid is up.
  task automatic xact(input int ta, input int tb_, input int ts, input int hold, input bit clr);
    exp_t e, got;
    int   n;
    e         = model(ta, tb_, ts);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a = 4'(ta); b = 4'(tb_); s = 5'(ts);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; return; end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); s = 5'($urandom);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
    chk("latency", n, 5);
    @(negedge clk);
    if (!out_valid) begin void'(sb.pop_front()); return; end
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_diff", int'(out_diff), int'(e.d));
      chk("bp_ok", int'(out_ok), int'(e.ok));
      chk("bp_in_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      a = 4'($urandom); b = 4'($urandom); s = 5'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = sb.pop_front();
    chk("out_valid", int'(out_valid), 1);
    chk("out_diff", int'(out_diff), int'(got.d));
    chk("out_ok", int'(out_ok), int'(got.ok));
    err_clr = clr;
    if (clr)                       mcnt = 0;
    else if (!got.ok && mcnt < 255) mcnt++;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cnt", int'(err_cnt), mcnt);
    chk("idle_after", int'(in_ready), 1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_diff", int'(out_diff), 0);
    chk("rst_out_ok", int'(out_ok), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    xact(5, 3, 8, 0, 0);
    xact(15, 15, 30, 0, 0);
    xact(15, 15, 31, 0, 0);
    xact(0, 3, 2, 0, 0);
    xact(7, 2, 9, 4, 0);
    xact(1, 1, 9, 4, 0);
    for (int i = 0; i < 20; i++) begin
      int ra, rb, rs;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : ra + rb;
      xact(ra, rb, rs, $urandom_range(0, 2), 1'b0);
    end

    for (int i = 0; i < 256; i++) xact(0, 3, 2, 0, 0);
    chk("sat_err_cnt", int'(err_cnt), 255);
    xact(0, 3, 2, 0, 1);
    xact(3, 4, 8, 0, 0);

    // Reset while idx==2 in SUB: transaction discarded, counter cleared
    out_ready = 1'b1;
    in_valid = 1'b1; a = 4'd1; b = 4'd2; s = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    mcnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    xact(1, 1, 2, 0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
